datapath_mc: RTL

Multi-cycle RV32I datapath with an internal instruction sequencer and ready/ack handshakes to instruction and data memory, so both memories may have variable latency. It replaces the single-cycle datapath and is driven by the same external combinational controller, which decodes `kind`/`funct3`/`funct7`. It adds:
- a branch comparator;
- a JALR target LSB clear;
- optional sub-word load/store support.

---
 rtl/datapath_mc.sv | 365 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/datapath_mc.sv
// -----------------------------------------------------------------------------
// datapath_mc -- multi-cycle RV32I datapath with an internal sequencer
//
// Each instruction steps FETCH -> DECODE -> EXEC -> (MEM) -> WB. Instruction
// and data memories use req/ack handshakes, so either may stretch a state by
// any number of wait cycles. An external combinational controller decodes
// kind/funct3/funct7 and drives the sel_* / control inputs back in.
//
// Optional feature macro: SUBWORD_MEM_EN
//   defined   : LB/LH/LW/LBU/LHU and SB/SH/SW by funct3, lane byte enables,
//               lane-aligned store data, sign/zero-extended loads,
//               halfword alignment check.
//   undefined : word-only accesses, dmem_be all ones, word alignment only.
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   kind                  instruction class decoded from IR opcode:
//                           0 other/NOP, 1 OP, 2 OP-IMM, 3 LOAD, 4 STORE,
//                           5 BRANCH, 6 JAL, 7 JALR, 8 LUI, 9 AUIPC
//   funct3, funct7        IR fields
//   imem_req/addr/ack/rdata  instruction fetch handshake
//   dmem_req/we/be/addr/wdata/ack/rdata  data memory handshake
//   sel_alu0              ALU operand 0: 0 = A, 1 = PC
//   sel_alu1              ALU operand 1: 0 = B, 1 = imm
//   alu_op                0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR,
//                         6 SRL, 7 SRA, 8 OR, 9 AND (others ADD)
//   sel_ex                ALUOUT source: 0 = ALU result, 1 = imm
//   sel_res               WB source: 0 = ALUOUT, 1 = MDR
//   sel_rf_wr             WB source override: 1 = PC+4 (link)
//   sel_pc                jump: next PC = ALUOUT with bit 0 cleared
//   rf_wr, mem_rd, mem_wr, is_branch  control strobes
//   retire                one-cycle pulse in WB
//   fault                 misaligned access; held in HALT until reset
//   pc_out                current PC
// -----------------------------------------------------------------------------
module datapath_mc #(
   parameter int               WIDTH     = 32,
   parameter int               IADDR     = 10,
   parameter int               DADDR     = 10,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   localparam int              INSTR_BIT = 4,
   localparam int              OP_BIT    = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [INSTR_BIT-1:0]   kind,
   output logic [2:0]             funct3,
   output logic [6:0]             funct7,
   output logic                   imem_req,
   output logic [IADDR-1:0]       imem_addr,
   input  logic                   imem_ack,
   input  logic [WIDTH-1:0]       imem_rdata,
   output logic                   dmem_req,
   output logic                   dmem_we,
   output logic [WIDTH/8-1:0]     dmem_be,
   output logic [DADDR-1:0]       dmem_addr,
   output logic [WIDTH-1:0]       dmem_wdata,
   input  logic                   dmem_ack,
   input  logic [WIDTH-1:0]       dmem_rdata,
   input  logic                   sel_alu0,
   input  logic                   sel_alu1,
   input  logic [OP_BIT:0]        alu_op,
   input  logic                   sel_ex,
   input  logic                   sel_res,
   input  logic                   sel_rf_wr,
   input  logic                   sel_pc,
   input  logic                   rf_wr,
   input  logic                   mem_rd,
   input  logic                   mem_wr,
   input  logic                   is_branch,
   output logic                   retire,
   output logic                   fault,
   output logic [WIDTH-1:0]       pc_out
);

   localparam int SH_W = $clog2(WIDTH);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [OP_BIT:0] ALU_ADD  = 4'd0;
   localparam logic [OP_BIT:0] ALU_SUB  = 4'd1;
   localparam logic [OP_BIT:0] ALU_SLL  = 4'd2;
   localparam logic [OP_BIT:0] ALU_SLT  = 4'd3;
   localparam logic [OP_BIT:0] ALU_SLTU = 4'd4;
   localparam logic [OP_BIT:0] ALU_XOR  = 4'd5;
   localparam logic [OP_BIT:0] ALU_SRL  = 4'd6;
   localparam logic [OP_BIT:0] ALU_SRA  = 4'd7;
   localparam logic [OP_BIT:0] ALU_OR   = 4'd8;
   localparam logic [OP_BIT:0] ALU_AND  = 4'd9;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------
   function automatic logic [INSTR_BIT-1:0] kind_f(input logic [6:0] opc);
      logic [INSTR_BIT-1:0] k;
      case (opc)
         OPC_OP:     k = 4'd1;
         OPC_OPIMM:  k = 4'd2;
         OPC_LOAD:   k = 4'd3;
         OPC_STORE:  k = 4'd4;
         OPC_BRANCH: k = 4'd5;
         OPC_JAL:    k = 4'd6;
         OPC_JALR:   k = 4'd7;
         OPC_LUI:    k = 4'd8;
         OPC_AUIPC:  k = 4'd9;
         default:    k = 4'd0;
      endcase
      return k;
   endfunction

   function automatic logic [WIDTH-1:0] imm_f(input logic [WIDTH-1:0] i);
      logic [WIDTH-1:0] r;
      case (i[6:0])
         OPC_OPIMM, OPC_LOAD, OPC_JALR:
            r = {{20{i[31]}}, i[31:20]};
         OPC_STORE:
            r = {{20{i[31]}}, i[31:25], i[11:7]};
         OPC_BRANCH:
            r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            r = {i[31:12], 12'b0};
         OPC_JAL:
            r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default:
            r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] alu_f(input logic [OP_BIT:0]       op,
                                              input logic signed [WIDTH-1:0] x,
                                              input logic signed [WIDTH-1:0] y);
      logic [SH_W-1:0]  sh;
      logic [WIDTH-1:0] r;
      sh = y[SH_W-1:0];
      case (op)
         ALU_SUB:  r = x - y;
         ALU_SLL:  r = x << sh;
         ALU_SLT:  r = {{(WIDTH-1){1'b0}}, (x < y)};
         ALU_SLTU: r = {{(WIDTH-1){1'b0}}, ($unsigned(x) < $unsigned(y))};
         ALU_XOR:  r = x ^ y;
         ALU_SRL:  r = $unsigned(x) >> sh;
         ALU_SRA:  r = x >>> sh;
         ALU_OR:   r = x | y;
         ALU_AND:  r = x & y;
         default:  r = x + y;
      endcase
      return r;
   endfunction

   function automatic logic branch_f(input logic [2:0]              f3,
                                     input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y);
      logic t;
      case (f3)
         3'b000:  t = (x == y);
         3'b001:  t = (x != y);
         3'b100:  t = (x <  y);
         3'b101:  t = (x >= y);
         3'b110:  t = ($unsigned(x) <  $unsigned(y));
         3'b111:  t = ($unsigned(x) >= $unsigned(y));
         default: t = 1'b0;
      endcase
      return t;
   endfunction

`ifdef SUBWORD_MEM_EN
   // sz = funct3[1:0]: 00 byte, 01 halfword, otherwise word
   function automatic logic misaligned_f(input logic [1:0] sz, input logic [1:0] lo);
      logic m;
      case (sz)
         2'b00:   m = 1'b0;
         2'b01:   m = lo[0];
         default: m = |lo;
      endcase
      return m;
   endfunction

   function automatic logic [WIDTH/8-1:0] lane_mask_f(input logic [1:0] sz,
                                                      input logic [1:0] lo);
      logic [WIDTH/8-1:0] m;
      case (sz)
         2'b00:   m = 4'b0001 << lo;
         2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
         default: m = '1;
      endcase
      return m;
   endfunction

   function automatic logic [WIDTH-1:0] store_align_f(input logic [1:0]       sz,
                                                      input logic [1:0]       lo,
                                                      input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      case (sz)
         2'b00:   r = {24'b0, d[7:0]}  << {lo, 3'b000};
         2'b01:   r = {16'b0, d[15:0]} << {lo[1], 4'b0000};
         default: r = d;
      endcase
      return r;
   endfunction

   // Shift the addressed lane down to bit 0, then extend per funct3.
   function automatic logic [WIDTH-1:0] load_extract_f(input logic [2:0]       f3,
                                                       input logic [1:0]       lo,
                                                       input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] sh;
      logic [WIDTH-1:0] r;
      sh = d >> {lo, 3'b000};
      case (f3)
         3'b000:  r = {{24{sh[7]}},  sh[7:0]};
         3'b001:  r = {{16{sh[15]}}, sh[15:0]};
         3'b100:  r = {24'b0, sh[7:0]};
         3'b101:  r = {16'b0, sh[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction
`endif

   // ---------------------------------------------------------------------------
   // State and registers
   // ---------------------------------------------------------------------------
   state_t           state, state_nx;
   logic [WIDTH-1:0] pc, pc_nx;
   logic [WIDTH-1:0] ir_p0;
   logic [WIDTH-1:0] a_p1, b_p1, imm_p1;
   logic [WIDTH-1:0] aluout_p2;
   logic             taken_p2;
   logic [WIDTH-1:0] mdr_p3;
   logic [WIDTH-1:0] rf [32];

   logic [4:0]       rs1, rs2, rd;
   logic [WIDTH-1:0] rs1_val, rs2_val;
   logic [WIDTH-1:0] op0, op1, alu_res, ex_res;
   logic [WIDTH-1:0] pc_plus4, wb_data;
   logic             mem_misaligned;
   logic             rf_we;
   logic [WIDTH/8-1:0] be_w;
   logic [WIDTH-1:0] wdata_w, load_w;

   assign rs1      = ir_p0[19:15];
   assign rs2      = ir_p0[24:20];
   assign rd       = ir_p0[11:7];
   assign rs1_val  = (rs1 == 5'd0) ? '0 : rf[rs1];
   assign rs2_val  = (rs2 == 5'd0) ? '0 : rf[rs2];

   assign op0      = sel_alu0 ? pc : a_p1;
   assign op1      = sel_alu1 ? imm_p1 : b_p1;
   assign alu_res  = alu_f(alu_op, op0, op1);
   assign ex_res   = sel_ex ? imm_p1 : alu_res;

   assign pc_plus4 = pc + WIDTH'(4);
   assign wb_data  = sel_rf_wr ? pc_plus4 : (sel_res ? mdr_p3 : aluout_p2);
   assign rf_we    = (state == S_WB) && rf_wr && (rd != 5'd0) && !reset;

`ifdef SUBWORD_MEM_EN
   assign mem_misaligned = misaligned_f(ir_p0[13:12], ex_res[1:0]);
   assign be_w           = lane_mask_f(ir_p0[13:12], aluout_p2[1:0]);
   assign wdata_w        = store_align_f(ir_p0[13:12], aluout_p2[1:0], b_p1);
   assign load_w         = load_extract_f(ir_p0[14:12], aluout_p2[1:0], dmem_rdata);
`else
   assign mem_misaligned = |ex_res[1:0];
   assign be_w           = '1;
   assign wdata_w        = b_p1;
   assign load_w         = dmem_rdata;
`endif

   // ---------------------------------------------------------------------------
   // Sequencer next state and next PC
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH:  if (imem_ack) state_nx = S_DECODE;
         S_DECODE: state_nx = S_EXEC;
         S_EXEC: begin
            if (mem_rd || mem_wr)
               state_nx = mem_misaligned ? S_HALT : S_MEM;
            else
               state_nx = S_WB;
         end
         S_MEM:    if (dmem_ack) state_nx = S_WB;
         S_WB:     state_nx = S_FETCH;
         S_HALT:   state_nx = S_HALT;
         default:  state_nx = S_FETCH;
      endcase
   end

   always_comb begin
      pc_nx = pc_plus4;
      if (is_branch)
         pc_nx = taken_p2 ? aluout_p2 : pc_plus4;
      else if (sel_pc)
         pc_nx = {aluout_p2[WIDTH-1:1], 1'b0};
   end

   // Control registers: state, PC and IR carry reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         ir_p0 <= '0;
      end else begin
         state <= state_nx;
         if (state == S_FETCH && imem_ack)
            ir_p0 <= imem_rdata;
         if (state == S_WB)
            pc <= pc_nx;
      end
   end

   // DECODE -> EXEC boundary: operands and immediate
   // EXEC -> MEM/WB boundary: ALUOUT and branch decision
   // MEM -> WB boundary: extended load data
   always_ff @(posedge clk) begin
      case (state)
         S_DECODE: begin
            a_p1   <= rs1_val;
            b_p1   <= rs2_val;
            imm_p1 <= imm_f(ir_p0);
         end
         S_EXEC: begin
            aluout_p2 <= ex_res;
            taken_p2  <= branch_f(ir_p0[14:12], a_p1, b_p1);
         end
         S_MEM: begin
            if (dmem_ack && mem_rd)
               mdr_p3 <= load_w;
         end
         default: ;
      endcase
      if (rf_we)
         rf[rd] <= wb_data;
   end

   // ---------------------------------------------------------------------------
   // Outputs: requests decode the registered state and drop during reset
   // ---------------------------------------------------------------------------
   assign kind       = kind_f(ir_p0[6:0]);
   assign funct3     = ir_p0[14:12];
   assign funct7     = ir_p0[31:25];
   assign imem_req   = (state == S_FETCH) && !reset;
   assign imem_addr  = pc[IADDR-1:0];
   assign dmem_req   = (state == S_MEM) && !reset;
   assign dmem_we    = dmem_req && mem_wr;
   assign dmem_be    = dmem_req ? be_w : '0;
   assign dmem_addr  = aluout_p2[DADDR-1:0];
   assign dmem_wdata = wdata_w;
   assign retire     = (state == S_WB) && !reset;
   assign fault      = (state == S_HALT);
   assign pc_out     = pc;

endmodule
